// File: rtl/shifter_pkg.sv
// Shared types and sizes for the 32-bit integer barrel shifter.
// Latency: none (package only; no logic).
// Backpressure: not applicable.
package shifter_pkg;

    localparam int WIDTH = 32;
    localparam int SA_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2
    } shift_mode_t;

    // Left shifts ignore Arith, so SLA collapses onto SLL.
    function automatic shift_mode_t decode_mode(input logic right, input logic arith);
        if (!right) begin
            return SLL;
        end else if (arith) begin
            return SRA;
        end
        return SRL;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One log stage of the barrel shifter: shifts by DIST when enabled, else passes data through.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    // dir=1 shifts right, dir=0 shifts left; vacated bits take the fill bit.
    always_comb begin
        result = data;
        if (enable) begin
            if (dir) begin
                result = {{DIST{fill}}, data[WIDTH-1:DIST]};
            end else begin
                result = {data[WIDTH-1-DIST:0], {DIST{fill}}};
            end
        end
    end

endmodule

// File: rtl/shifter_32.sv
// 32-bit barrel shifter (SLL/SRL/SRA) for the EX stage; five log stages then an output register.
// Latency: 1 cycle from in_valid to out_valid; Sh holds when no op is accepted.
// Backpressure: none; a new operation may be accepted every cycle.
module shifter_32
    import shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [SA_W-1:0]  Sa,
    input  logic             Arith,
    input  logic             Right,
    output logic [WIDTH-1:0] Sh,
    output logic             out_valid
);

    shift_mode_t      mode;
    logic             fill;
    logic [WIDTH-1:0] chain [0:SA_W];

    // Only an arithmetic right shift replicates the sign; everything else fills with zero.
    always_comb begin
        mode = decode_mode(Right, Arith);
        fill = (mode == SRA) ? X[WIDTH-1] : 1'b0;
    end

    assign chain[0] = X;

    // Stage i handles shift-amount bit SA_W-1-i, i.e. distances 16, 8, 4, 2, 1.
    for (genvar i = 0; i < SA_W; i++) begin : g_stage
        shift_stage #(
            .DIST (1 << (SA_W - 1 - i))
        ) u_stage (
            .data   (chain[i]),
            .enable (Sa[SA_W-1-i]),
            .dir    (Right),
            .fill   (fill),
            .result (chain[i+1])
        );
    end

    // Register the result; reset wins over a valid op, idle cycles hold Sh.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sh        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sh <= chain[SA_W];
            end
        end
    end

endmodule

// File: tb/tb_shifter_32.sv
// Self-checking bench for shifter_32: directed vectors, pipeline/reset cases, random ops.
// Latency: expects each accepted op one cycle later on Sh/out_valid.
// Backpressure: none in the DUT; the bench drives ops back to back or with gaps.
module tb_shifter_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] X;
    logic [4:0]  Sa;
    logic        Arith;
    logic        Right;
    logic [31:0] Sh;
    logic        out_valid;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] last_exp;

    shifter_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .X         (X),
        .Sa        (Sa),
        .Arith     (Arith),
        .Right     (Right),
        .Sh        (Sh),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] sa,
                                          input logic ar, input logic rt);
        if (!rt) return x << sa;
        if (ar)  return 32'($signed(x) >>> sa);
        return x >> sa;
    endfunction

    task automatic drive(input string tag, input logic [31:0] x, input logic [4:0] sa,
                         input logic ar, input logic rt, input logic [31:0] exp);
        @(negedge clk);
        in_valid = 1'b1;
        X        = x;
        Sa       = sa;
        Arith    = ar;
        Right    = rt;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        last_exp = exp;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Scoreboard: every out_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_valid_unexpected", 32'(out_valid), 32'd0);
            end else begin
                chk(tag_q.pop_front(), Sh, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_exp = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        X        = '0;
        Sa       = '0;
        Arith    = 1'b0;
        Right    = 1'b0;

        // Reset for two cycles, then idle.
        repeat (2) @(negedge clk);
        chk("rst_sh", Sh, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_sh", Sh, 32'h0);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed vectors, issued back to back.
        drive("sll_4",        32'h12345678, 5'd4,   1'b0, 1'b0, 32'h23456780);
        drive("sll_ones_4",   32'hFFFFFFFF, 5'd4,   1'b0, 1'b0, 32'hFFFFFFF0);
        drive("sll_8",        32'hDEADBEEF, 5'd8,   1'b0, 1'b0, 32'hADBEEF00);
        drive("sll_a_16",     32'hAAAAAAAA, 5'd16,  1'b0, 1'b0, 32'hAAAA0000);
        drive("sll_5_16",     32'h55555555, 5'd16,  1'b0, 1'b0, 32'h55550000);
        drive("sll_msb_out",  32'h80000000, 5'd1,   1'b0, 1'b0, 32'h00000000);
        drive("sll_7f_1",     32'h7FFFFFFF, 5'd1,   1'b0, 1'b0, 32'hFFFFFFFE);
        drive("sll_31",       32'hFFFFFFFF, 5'd31,  1'b0, 1'b0, 32'h80000000);
        drive("sll_0",        32'h12345678, 5'd0,   1'b0, 1'b0, 32'h12345678);
        drive("sll_neg4",     32'h12345678, 5'(-4), 1'b0, 1'b0, 32'h80000000);
        drive("sll_32",       32'h12345678, 5'(32), 1'b0, 1'b0, 32'h12345678);
        drive("sla_1",        32'h12345678, 5'd1,   1'b1, 1'b0, 32'h2468ACF0);
        drive("sla_msb",      32'h80000000, 5'd1,   1'b1, 1'b0, 32'h00000000);
        drive("srl_4",        32'h80000000, 5'd4,   1'b0, 1'b1, 32'h08000000);
        drive("sra_4_neg",    32'h80000000, 5'd4,   1'b1, 1'b1, 32'hF8000000);
        drive("sra_4_pos",    32'h12345678, 5'd4,   1'b1, 1'b1, 32'h01234567);
        drive("sra_31",       32'h80000000, 5'd31,  1'b1, 1'b1, 32'hFFFFFFFF);
        drive("srl_31",       32'h80000000, 5'd31,  1'b0, 1'b1, 32'h00000001);
        drive("sra_0",        32'h80000001, 5'd0,   1'b1, 1'b1, 32'h80000001);

        // Gap: out_valid drops, Sh holds the last result.
        idle();
        @(negedge clk);
        chk("gap_out_valid", 32'(out_valid), 32'd0);
        chk("gap_sh_held", Sh, last_exp);
        @(negedge clk);
        chk("gap2_sh_held", Sh, last_exp);

        // Reset mid-stream beats a valid op on the same edge.
        drive("pre_rst", 32'h0000F00F, 5'd4, 1'b0, 1'b1, 32'h00000F00);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        X        = 32'hFFFFFFFF;
        Sa       = 5'd3;
        @(negedge clk);
        chk("midrst_sh", Sh, 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Random ops with occasional idle cycles.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] rx;
            logic [4:0]  rsa;
            logic        rar;
            logic        rrt;
            rx  = $urandom;
            rsa = 5'($urandom_range(0, 31));
            rar = 1'($urandom_range(0, 1));
            rrt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                idle();
            end else begin
                drive("random", rx, rsa, rar, rrt, model(rx, rsa, rar, rrt));
            end
        end

        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
